// File: rtl/benes_pkg.sv
// Shared definitions for the pipelined Benes distribution network.
//
// Provides the derived-size helpers (switch level count, config width),
// the partner distance of each inner switch level, the rule that decides
// which levels are followed by a pipeline register, and the default lane
// type.
package benes_pkg;

  localparam int DATA_TYPE_DEF = 16;

  typedef logic [DATA_TYPE_DEF-1:0] lane_t;

  // Input buffer + 2*log2(N)-1 butterfly levels + final pair-swap level.
  function automatic int calc_levels(input int num_pes);
    return 2 * $clog2(num_pes) + 1;
  endfunction

  // Two bits (select, gate) per lane for each inner level, one per lane
  // for the final level.
  function automatic int calc_mux_w(input int num_pes);
    return 2 * (calc_levels(num_pes) - 2) * num_pes + num_pes;
  endfunction

  // Inner levels fold inward then outward: for 8 lanes 4,2,1,2,4.
  function automatic int partner_dist(input int num_pes, input int level);
    int d;
    d = (level - 1) - ($clog2(num_pes) - 1);
    if (d < 0) d = -d;
    return 1 << d;
  endfunction

  // The last level is always registered so the output never has a
  // combinational path from the input lanes.
  function automatic bit has_stage_reg(input int level, input int pipe_every,
                                       input int levels);
    return (((level + 1) % pipe_every) == 0) || (level == levels - 1);
  endfunction

  function automatic int calc_latency(input int levels, input int pipe_every);
    return (levels + pipe_every - 1) / pipe_every;
  endfunction

endpackage

// File: rtl/benes_level.sv
// One combinational switch level of the Benes distribution network.
//
// Parameters:
//   LEVEL  - level index; 0 is the input buffer (pass-through), LEVELS-1 is
//            the final pair-swap level, everything between is an inner level
//   DIST   - partner distance (lane i pairs with lane i XOR DIST)
// Ports:
//   cfg_i  - config slice for this level; inner levels use {gate,sel} per
//            lane, the final level uses only the low NUM_PES select bits
//   data_i - incoming lanes, lane 0 at LSBs
//   data_o - switched lanes
module benes_level
  import benes_pkg::*;
#(
  parameter int DATA_TYPE = 16,
  parameter int NUM_PES   = 8,
  parameter int LEVELS    = calc_levels(NUM_PES),
  parameter int LEVEL     = 0,
  parameter int DIST      = 1
) (
  input  logic [2*NUM_PES-1:0]         cfg_i,
  input  logic [NUM_PES*DATA_TYPE-1:0] data_i,
  output logic [NUM_PES*DATA_TYPE-1:0] data_o
);

  // The input buffer ignores its config and the final level only reads the
  // lower half; fold the slice so the leftover bits are visibly consumed.
  logic cfg_unused;
  assign cfg_unused = ^cfg_i;

  for (genvar i = 0; i < NUM_PES; i++) begin : g_lane
    localparam int P = i ^ DIST;
    logic sel;
    logic gate;

    if (LEVEL == 0) begin : g_in
      assign sel  = 1'b0;
      assign gate = 1'b0;
    end else if (LEVEL == LEVELS - 1) begin : g_fin
      assign sel  = cfg_i[i];
      assign gate = 1'b0;
    end else begin : g_inner
      assign sel  = cfg_i[2*i];
      assign gate = cfg_i[2*i+1];
    end

    assign data_o[i*DATA_TYPE +: DATA_TYPE] =
        gate ? '0 :
        (sel ? data_i[P*DATA_TYPE +: DATA_TYPE] : data_i[i*DATA_TYPE +: DATA_TYPE]);
  end

endmodule

// File: rtl/benes_dist_pipe.sv
// Pipelined Benes distribution network with valid/ready flow control.
//
// Routes NUM_PES lanes of DATA_TYPE bits through LEVELS switch levels. The
// active mux config is sampled when a beat is accepted and travels with the
// beat, so a config load never disturbs beats already in the pipe. All-zero
// config is identity routing.
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   i_cfg_valid     - load i_cfg_mux_bus into the active config register
//   i_cfg_mux_bus   - mux config (MUX_W bits)
//   i_valid/o_ready - input beat handshake, i_data_bus lane 0 at LSBs
//   o_valid/i_ready - output beat handshake, o_dist_bus routed lanes
//   o_pkt_count     - delivered beat count
//
// Build option: define BENES_PERF_CNT_EN to enable the 16-bit delivered-beat
// counter on o_pkt_count; otherwise o_pkt_count is tied to zero.
module benes_dist_pipe
  import benes_pkg::*;
#(
  parameter int DATA_TYPE  = 16,
  parameter int NUM_PES    = 8,
  parameter int LEVELS     = calc_levels(NUM_PES),
  parameter int MUX_W      = calc_mux_w(NUM_PES),
  parameter int PIPE_EVERY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cfg_valid,
  input  logic [MUX_W-1:0]             i_cfg_mux_bus,
  input  logic                         i_valid,
  input  logic [NUM_PES*DATA_TYPE-1:0] i_data_bus,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic [NUM_PES*DATA_TYPE-1:0] o_dist_bus,
  input  logic                         i_ready,
  output logic [15:0]                  o_pkt_count
);

  localparam int BUS_W = NUM_PES * DATA_TYPE;

  logic [MUX_W-1:0] cfg_q;
  logic             en;

  // pipe_*[j] is what level j sees; pipe_data/pipe_vld[LEVELS] is the output.
  logic [BUS_W-1:0] pipe_data [LEVELS+1];
  logic             pipe_vld  [LEVELS+1];
  logic [MUX_W-1:0] pipe_cfg  [LEVELS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q <= '0;
    end else if (i_cfg_valid) begin
      cfg_q <= i_cfg_mux_bus;
    end
  end

  // Single global enable: the whole pipe stalls together, bubbles included.
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  assign pipe_data[0] = i_data_bus;
  assign pipe_vld[0]  = i_valid;
  assign pipe_cfg[0]  = cfg_q;

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int DIST = ((j == 0) || (j == LEVELS - 1)) ? 1 : partner_dist(NUM_PES, j);

    logic [2*NUM_PES-1:0] lvl_cfg;
    logic [BUS_W-1:0]     lvl_data_sw;

    if (j == 0) begin : g_cfg_in
      assign lvl_cfg = '0;
    end else if (j == LEVELS - 1) begin : g_cfg_fin
      logic cfg_unused;
      assign cfg_unused = ^pipe_cfg[j][MUX_W-NUM_PES-1:0];
      assign lvl_cfg    = {{NUM_PES{1'b0}}, pipe_cfg[j][MUX_W-1 -: NUM_PES]};
    end else begin : g_cfg_inner
      assign lvl_cfg = pipe_cfg[j][2*NUM_PES*(j-1) +: 2*NUM_PES];
    end

    benes_level #(
      .DATA_TYPE (DATA_TYPE),
      .NUM_PES   (NUM_PES),
      .LEVELS    (LEVELS),
      .LEVEL     (j),
      .DIST      (DIST)
    ) u_level (
      .cfg_i  (lvl_cfg),
      .data_i (pipe_data[j]),
      .data_o (lvl_data_sw)
    );

    if (has_stage_reg(j, PIPE_EVERY, LEVELS)) begin : g_reg
      logic [BUS_W-1:0] data_q;
      logic             vld_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else if (en) begin
          data_q <= lvl_data_sw;
          vld_q  <= pipe_vld[j];
        end
      end

      assign pipe_data[j+1] = data_q;
      assign pipe_vld[j+1]  = vld_q;

      // Config is dead after the final level, so it is not carried further.
      if (j < LEVELS - 1) begin : g_cfg_reg
        logic [MUX_W-1:0] cfg_stage_q;

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            cfg_stage_q <= '0;
          end else if (en) begin
            cfg_stage_q <= pipe_cfg[j];
          end
        end

        assign pipe_cfg[j+1] = cfg_stage_q;
      end
    end else begin : g_comb
      // Only reachable for j < LEVELS-1: the final level is always registered.
      assign pipe_data[j+1] = lvl_data_sw;
      assign pipe_vld[j+1]  = pipe_vld[j];
      assign pipe_cfg[j+1]  = pipe_cfg[j];
    end
  end

  assign o_valid    = pipe_vld[LEVELS];
  assign o_dist_bus = pipe_data[LEVELS];

`ifdef BENES_PERF_CNT_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (o_valid && i_ready) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign o_pkt_count = pkt_cnt_q;
`else
  assign o_pkt_count = '0;
`endif

endmodule

// File: doc/benes_dist_pipe.md
Name: benes_dist_pipe

Overview:
Parametrised, pipelined Benes distribution network for the SIGMA data-distribution path. Routes NUM_PES lanes of DATA_TYPE-bit operands to PE inputs under a per-beat mux configuration. Adds valid/ready flow control, registered pipeline stages, a config register whose value travels with each beat, and lane gating.
Successor to the single-shot combinational benes block; all-zero config remains identity routing.

Parameters:
DATA_TYPE, 16, lane width in bits
NUM_PES, 8, lanes; power of 2, 4..64
LEVELS, 2*$clog2(NUM_PES)+1, switch levels (derived; do not override)
MUX_W, 2*(LEVELS-2)*NUM_PES+NUM_PES, config width (derived)
PIPE_EVERY, 1, register after every PIPE_EVERY levels (1..LEVELS)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_cfg_valid  in  1  load new mux config
i_cfg_mux_bus  in  MUX_W  mux config
i_valid  in  1  input beat valid
i_data_bus  in  NUM_PES*DATA_TYPE  input lanes, lane 0 at LSBs
o_ready  out  1  beat accepted when i_valid && o_ready
o_valid  out  1  output beat valid
o_dist_bus  out  NUM_PES*DATA_TYPE  routed lanes
i_ready  in  1  downstream accepts output
o_pkt_count  out  16  beats delivered (see Optional Feature)

Behaviour:
- Reset (rst low, async): all stage valid bits 0, o_valid 0, o_dist_bus 0, active config 0 (identity), o_pkt_count 0. In-flight beats are discarded.
- Level map: level 0 is the input buffer and has no config bits. Inner levels l=1..LEVELS-2 use bits [2*NUM_PES*(l-1) +: 2*NUM_PES]. The final level uses the top NUM_PES bits.
- Inner level, lane i:
  - k = l-1; partner p = i XOR 2^|k-(log2(NUM_PES)-1)|. For NUM_PES=8 the distances are 4,2,1,2,4.
  - Bit 2i selects the source: 0 = own lane, 1 = partner lane.
  - Bit 2i+1 = 1 forces the lane to 0 (gating).
- Final level, lane i: bit selects own (0) or lane i XOR 1 (1).
- Pipeline: a register stage follows level j when (j+1)%PIPE_EVERY==0 or j==LEVELS-1. Latency L = ceil(LEVELS/PIPE_EVERY) cycles from acceptance to o_valid; the output is always registered.
- Config: captured into the active register when i_cfg_valid. A beat accepted in the same cycle uses the old config. Each beat carries its own config copy through the stages, so in-flight beats are never affected by a config change.
- Flow control:
  - en = !o_valid || i_ready; o_ready = en. This is a combinational i_ready-to-o_ready path.
  - When en=0, all stages hold data, config and valid, and o_dist_bus is stable.
  - Bubbles advance only when en=1; no bubble collapsing.
- Throughput is 1 beat/cycle with i_ready held high. Order is preserved; no loss or duplication.
- Config load is accepted regardless of en.

Optional Feature:
BENES_PERF_CNT_EN
- Defined: o_pkt_count increments on o_valid && i_ready and wraps at 2^16. It clears only on reset.
- Undefined: o_pkt_count is tied to 0 and no counter logic is inferred.

Decomposition:
- Package benes_pkg:
  - localparam functions for LEVELS, MUX_W, partner distance and stage-register placement.
  - typedef lane_t (logic [DATA_TYPE-1:0]).
- Sub-module benes_level: one combinational switch level. It takes level index and config slice, with its partner distance as a parameter. The top generates LEVELS instances plus stage registers.

Test Plan:
Fixed setup for all cases: NUM_PES=8, DATA_TYPE=16, PIPE_EVERY=1, i_data_bus=128'h7777_6666_5555_4444_3333_2222_1111_0000.
1. Identity: cfg all 0, one beat, i_ready=1 -> o_valid rises exactly 7 cycles later; o_dist_bus equals input; o_valid high for one cycle.
2. Adjacent swap: cfg bits [32 +: 16]=16'h5555 (level 3, distance 1), all other bits 0 -> o_dist_bus=128'h6666_7777_4444_5555_2222_3333_0000_1111.
3. Gating: cfg bits [0 +: 16]=16'hAAAA -> o_dist_bus=0 with o_valid=1.
4. Backpressure:
   - Stimulus: 3 back-to-back beats (identity cfg, data 0x..00, 0x..01, 0x..02 in lane 0), i_ready=0 from the cycle the first output appears, held 5 cycles.
   - Response: o_valid=1, o_dist_bus stable, o_ready=0.
   - After releasing i_ready: the 3 beats exit in order on consecutive cycles.
5. Config race: beat A with cfg=0; cfg=swap (test 2) in the same cycle beat B is accepted; beat C one cycle later -> A and B identity, C swapped.
6. Reset mid-flight:
   - Stimulus: 4 beats in flight, then pull rst low between clock edges.
   - During reset: o_valid=0 and o_dist_bus=0 immediately.
   - After release: no stale beats; the next beat routes with identity config. With BENES_PERF_CNT_EN, o_pkt_count=0.
